// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: raw instruction FIFO, combinational decode, registered output bundle
// Optional feature macro: DECODE_RV32M_EN (OP with funct7=0000001 decodes as MULDIV instead of ILLEGAL)
module decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] ins_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [3:0]  opclass_o,
  output logic        illegal_o,
  output logic        overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [3:0] OC_LUI = 4'd0, OC_AUIPC = 4'd1, OC_JAL = 4'd2, OC_JALR = 4'd3;
  localparam logic [3:0] OC_BRANCH = 4'd4, OC_LOAD = 4'd5, OC_STORE = 4'd6, OC_OP_IMM = 4'd7;
  localparam logic [3:0] OC_OP = 4'd8, OC_MISC_MEM = 4'd9, OC_SYSTEM = 4'd10;
  localparam logic [3:0] OC_MULDIV = 4'd11, OC_ILLEGAL = 4'd15;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  out_state_e  state_q, state_d;
  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, push_req, do_push, load, ovf_set;
  logic [31:0] h;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  dec_class;
  logic [31:0] dec_imm;
  logic        use_rd, use_rs1, use_rs2;

  logic [31:0] pc_q, ins_q, imm_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic        funct7b5_q, illegal_q, overflow_q;
  logic [3:0]  opclass_q;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_req   = !stall_i && !flush_i;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push    = push_req && (!fifo_full || load);
  assign ovf_set    = push_req && fifo_full && !load;

  // Output register occupancy: load whenever the head can move into a free slot.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (!flush_i) begin
      case (state_q)
        OUT_EMPTY: if (!fifo_empty) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
        OUT_FULL: if (ready_i) begin
          if (!fifo_empty) load = 1'b1;
          else state_d = OUT_EMPTY;
        end
        default: state_d = OUT_EMPTY;
      endcase
    end else begin
      state_d = OUT_EMPTY;
    end
  end

  // State register; flush empties the output slot as well as the FIFO.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  // FIFO pointers; a flush drops all buffered entries.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (load)    rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // FIFO storage holds {pc, ins}; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= {pc_i, ins_i};
  end

  assign h     = mem_q[rptr_q[AW-1:0]][31:0];
  assign imm_i = {{20{h[31]}}, h[31:20]};
  assign imm_s = {{20{h[31]}}, h[31:25], h[11:7]};
  assign imm_b = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
  assign imm_u = {h[31:12], 12'b0};
  assign imm_j = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};

  // Decode the FIFO head; illegal encodings clear all field enables and the immediate.
  always_comb begin
    dec_class = OC_ILLEGAL;
    dec_imm   = '0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    if (h[1:0] == 2'b11) begin
      case (h[6:0])
        7'b0110111: begin dec_class = OC_LUI;   dec_imm = imm_u; use_rd = 1'b1; end
        7'b0010111: begin dec_class = OC_AUIPC; dec_imm = imm_u; use_rd = 1'b1; end
        7'b1101111: begin dec_class = OC_JAL;   dec_imm = imm_j; use_rd = 1'b1; end
        7'b1100111: begin
          dec_class = OC_JALR; dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        end
        7'b1100011: begin
          if (h[14:13] != 2'b01) dec_class = OC_BRANCH;
          dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        7'b0000011: begin
          if (h[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_class = OC_LOAD;
          dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        end
        7'b0100011: begin
          if (h[14:12] inside {3'b000, 3'b001, 3'b010}) dec_class = OC_STORE;
          dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        7'b0010011: begin
          dec_class = OC_OP_IMM; dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        end
        7'b0110011: begin
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          if (h[31:25] == 7'b0000000 || h[31:25] == 7'b0100000) dec_class = OC_OP;
`ifdef DECODE_RV32M_EN
          else if (h[31:25] == 7'b0000001) dec_class = OC_MULDIV;
`else
          else dec_class = OC_ILLEGAL;
`endif
        end
        7'b0001111: begin
          dec_class = OC_MISC_MEM; dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        end
        7'b1110011: begin dec_class = OC_SYSTEM; use_rd = 1'b1; use_rs1 = 1'b1; end
        default:    dec_class = OC_ILLEGAL;
      endcase
    end
    if (dec_class == OC_ILLEGAL) begin
      dec_imm = '0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  // Output bundle register: loads on pop, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0; ins_q <= '0; imm_q <= '0;
      rd_q <= '0; rs1_q <= '0; rs2_q <= '0;
      funct3_q <= '0; funct7b5_q <= 1'b0;
      opclass_q <= OC_ILLEGAL; illegal_q <= 1'b0;
    end else if (load) begin
      pc_q       <= mem_q[rptr_q[AW-1:0]][63:32];
      ins_q      <= h;
      imm_q      <= dec_imm;
      rd_q       <= use_rd  ? h[11:7]  : 5'd0;
      rs1_q      <= use_rs1 ? h[19:15] : 5'd0;
      rs2_q      <= use_rs2 ? h[24:20] : 5'd0;
      funct3_q   <= h[14:12];
      funct7b5_q <= h[30];
      opclass_q  <= dec_class;
      illegal_q  <= (dec_class == OC_ILLEGAL);
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          overflow_q <= 1'b0;
    else if (ovf_set) overflow_q <= 1'b1;
  end

  assign ready_o    = !fifo_full;
  assign valid_o    = (state_q == OUT_FULL);
  assign pc_o       = pc_q;
  assign ins_o      = ins_q;
  assign rd_o       = rd_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;
  assign imm_o      = imm_q;
  assign funct3_o   = funct3_q;
  assign funct7b5_o = funct7b5_q;
  assign opclass_o  = opclass_q;
  assign illegal_o  = illegal_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed bench for decode_stage against a queue-based reference model
module tb_decode_stage;
  localparam int DEPTH = 2;

  logic        clk, rst, stall_i, flush_i, ready_i;
  logic [31:0] ins_i, pc_i;
  logic        ready_o, valid_o, funct7b5_o, illegal_o, overflow_o;
  logic [31:0] pc_o, ins_o, imm_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic [3:0]  opclass_o;

  decode_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ins_i(ins_i), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .ins_o(ins_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .opclass_o(opclass_o), .illegal_o(illegal_o), .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  oc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
  } dec_t;

  int total = 0;
  int bad = 0;

  logic [63:0] m_q [$];
  logic        m_valid, m_ill, m_ovf;
  logic [31:0] m_pc, m_ins;
  dec_t        m_dec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: classify by opcode, then pick fields and immediate from the class's format.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] ii, is, ib, iu, ij;
    logic [2:0] f3;
    logic [6:0] f7;
    s  = $signed(w);
    f3 = w[14:12];
    f7 = w[31:25];
    ii = s >>> 20;
    is = s >>> 20;
    is = (is & 32'hFFFF_FFE0) | 32'(w[11:7]);
    ib = s >>> 19;
    ib = (ib & 32'hFFFF_F000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    iu = w & 32'hFFFF_F000;
    ij = s >>> 11;
    ij = (ij & 32'hFFF0_0000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    d.oc = 4'd15;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h37: d.oc = 4'd0;
        7'h17: d.oc = 4'd1;
        7'h6F: d.oc = 4'd2;
        7'h67: d.oc = 4'd3;
        7'h63: d.oc = (f3 inside {0, 1, 4, 5, 6, 7}) ? 4'd4 : 4'd15;
        7'h03: d.oc = (f3 inside {0, 1, 2, 4, 5}) ? 4'd5 : 4'd15;
        7'h23: d.oc = (f3 inside {0, 1, 2}) ? 4'd6 : 4'd15;
        7'h13: d.oc = 4'd7;
        7'h33: begin
          if (f7 == 7'h00 || f7 == 7'h20) d.oc = 4'd8;
`ifdef DECODE_RV32M_EN
          else if (f7 == 7'h01) d.oc = 4'd11;
`endif
        end
        7'h0F: d.oc = 4'd9;
        7'h73: d.oc = 4'd10;
        default: d.oc = 4'd15;
      endcase
    end
    d.rd  = (d.oc inside {0, 1, 2, 3, 5, 7, 8, 9, 10, 11}) ? w[11:7]  : 5'd0;
    d.rs1 = (d.oc inside {3, 4, 5, 6, 7, 8, 9, 10, 11})    ? w[19:15] : 5'd0;
    d.rs2 = (d.oc inside {4, 6, 8, 11})                    ? w[24:20] : 5'd0;
    case (d.oc)
      4'd0, 4'd1:             d.imm = iu;
      4'd2:                   d.imm = ij;
      4'd3, 4'd5, 4'd7, 4'd9: d.imm = ii;
      4'd4:                   d.imm = ib;
      4'd6:                   d.imm = is;
      default:                d.imm = 32'd0;
    endcase
    return d;
  endfunction

  // Cycle-level model: pop the head into a free output slot, then push if room remains.
  task automatic model_update(input logic r, input logic st, input logic fl,
                              input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    logic [63:0] e;
    if (r) begin
      m_q.delete();
      m_valid = 1'b0; m_pc = '0; m_ins = '0; m_ill = 1'b0; m_ovf = 1'b0;
      m_dec = '{oc: 4'd15, imm: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
    end else if (fl) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      if (m_q.size() > 0 && (!m_valid || rdy)) begin
        e = m_q.pop_front();
        m_pc = e[63:32]; m_ins = e[31:0];
        m_dec = ref_decode(m_ins);
        m_ill = (m_dec.oc == 4'd15);
        m_valid = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (!st) begin
        if (m_q.size() < DEPTH) m_q.push_back({pc, ins});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(valid_o), 32'(m_valid));
    check("ready", 32'(ready_o), 32'(m_q.size() < DEPTH));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("pc", pc_o, m_pc);
    check("ins", ins_o, m_ins);
    check("rd", 32'(rd_o), 32'(m_dec.rd));
    check("rs1", 32'(rs1_o), 32'(m_dec.rs1));
    check("rs2", 32'(rs2_o), 32'(m_dec.rs2));
    check("imm", imm_o, m_dec.imm);
    check("funct3", 32'(funct3_o), 32'(m_ins[14:12]));
    check("funct7b5", 32'(funct7b5_o), 32'(m_ins[30]));
    check("opclass", 32'(opclass_o), 32'(m_dec.oc));
    check("illegal", 32'(illegal_o), 32'(m_ill));
  endtask

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    rst = r; stall_i = st; flush_i = fl; pc_i = pc; ins_i = ins; ready_i = rdy;
    @(posedge clk);
    model_update(r, st, fl, pc, ins, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b1, 1'b0, $urandom, $urandom, rdy);
  endtask

  task automatic offer_and_wait(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b0, 1'b0, 1'b0, pc, ins, 1'b1);
    idle(1'b1);
    idle(1'b1);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [11];
    logic [31:0] w;
    int sel;
    ops[0] = 7'h37; ops[1] = 7'h17; ops[2] = 7'h6F; ops[3] = 7'h67; ops[4] = 7'h63; ops[5] = 7'h03;
    ops[6] = 7'h23; ops[7] = 7'h13; ops[8] = 7'h33; ops[9] = 7'h0F; ops[10] = 7'h73;
    w = $urandom;
    sel = $urandom_range(0, 12);
    if (sel < 11) begin
      w[6:0] = ops[sel];
      if (sel == 8) begin
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
    end
    return w;
  endfunction

  initial begin
    m_valid = 1'b0; m_pc = '0; m_ins = '0; m_ill = 1'b0; m_ovf = 1'b0;
    m_dec = '{oc: 4'd15, imm: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
    rst = 1'b1; stall_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1; pc_i = '0; ins_i = '0;

    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_opclass", 32'(opclass_o), 32'd15);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    idle(1'b1);

    // addi x1,x0,5: visible two cycles after the offer, for one cycle
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093, 1'b1);
    check("addi_lat1", 32'(valid_o), 32'd0);
    idle(1'b1);
    check("addi_lat2", 32'(valid_o), 32'd1);
    check("addi_oc", 32'(opclass_o), 32'd7);
    check("addi_rd", 32'(rd_o), 32'd1);
    check("addi_rs1", 32'(rs1_o), 32'd0);
    check("addi_imm", imm_o, 32'h5);
    check("addi_pc", pc_o, 32'h0);
    idle(1'b1);
    check("addi_once", 32'(valid_o), 32'd0);

    offer_and_wait(32'h4, 32'hFE20_AE23);
    check("sw_oc", 32'(opclass_o), 32'd6);
    check("sw_rs1", 32'(rs1_o), 32'd1);
    check("sw_rs2", 32'(rs2_o), 32'd2);
    check("sw_rd", 32'(rd_o), 32'd0);
    check("sw_imm", imm_o, 32'hFFFF_FFFC);
    offer_and_wait(32'h8, 32'hFE00_0CE3);
    check("beq_oc", 32'(opclass_o), 32'd4);
    check("beq_imm", imm_o, 32'hFFFF_FFF8);

    // back-pressure: DEPTH+2 offers, last one dropped
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0000_0013, 1'b0);
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_head", pc_o, 32'h100);
    for (int i = 1; i <= DEPTH; i++) begin
      idle(1'b1);
      check("ovf_order_valid", 32'(valid_o), 32'd1);
      check("ovf_order_pc", pc_o, 32'h100 + 32'(4 * i));
    end
    idle(1'b1);
    check("ovf_drained", 32'(valid_o), 32'd0);

    // flush with two entries buffered and a new offer in the flush cycle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0000_0013, 1'b0);
    check("pre_flush_valid", 32'(valid_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h2F0, 32'h0000_0013, 1'b1);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("flush_gone", 32'(valid_o), 32'd0);
    end

    offer_and_wait(32'h300, 32'h0220_8033);
`ifdef DECODE_RV32M_EN
    check("mul_oc", 32'(opclass_o), 32'd11);
    check("mul_ill", 32'(illegal_o), 32'd0);
`else
    check("mul_oc", 32'(opclass_o), 32'd15);
    check("mul_ill", 32'(illegal_o), 32'd1);
`endif
    offer_and_wait(32'h304, 32'hFFFF_FFFF);
    check("ones_ill", 32'(illegal_o), 32'd1);
    check("ones_imm", imm_o, 32'd0);

    // reset while busy
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h400 + 32'(4 * i), rand_ins(), 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h500, 32'h0000_0013, 1'b1);
    check("mrst_valid", 32'(valid_o), 32'd0);
    check("mrst_pc", pc_o, 32'd0);
    check("mrst_ins", ins_o, 32'd0);
    check("mrst_regs", {17'd0, rd_o, rs1_o, rs2_o}, 32'd0);
    check("mrst_imm", imm_o, 32'd0);
    check("mrst_f", {28'd0, funct3_o, funct7b5_o}, 32'd0);
    check("mrst_ovf", 32'(overflow_o), 32'd0);
    check("mrst_oc", 32'(opclass_o), 32'd15);
    check("mrst_ill", 32'(illegal_o), 32'd0);
    check("mrst_ready", 32'(ready_o), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 0), ($urandom_range(0, 19) == 0),
           $urandom, rand_ins(), ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage, directly downstream of the fetch stage. It captures each instruction word and PC that fetch presents and buffers them in a small FIFO. It decodes each entry into RV32I register indices, an immediate, and an operation class, then hands the decoded bundle to execute over a valid/ready handshake. A jump flush discards everything in flight.

## Interface
- DEPTH, 2: raw instruction FIFO entries; power of two, 2..8.
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- ins_i  in  32  instruction word from fetch.
- pc_i  in  32  PC of ins_i.
- stall_i  in  1  fetch stall; an instruction is offered in every cycle where stall_i=0.
- flush_i  in  1  jump taken; same signal that drives fetch jmp_i.
- ready_o  out  1  FIFO not full (advisory to fetch/top).
- valid_o  out  1  decoded bundle valid.
- ready_i  in  1  execute accepts the bundle.
- pc_o  out  32  PC of the bundle.
- ins_o  out  32  raw instruction of the bundle.
- rd_o, rs1_o, rs2_o  out  5 each  ins[11:7], ins[19:15], ins[24:20]; forced to 0 when the class does not use that field.
- imm_o  out  32  sign-extended immediate (I/S/B/U/J format), 0 for R-type/SYSTEM.
- funct3_o  out  3  ins[14:12].
- funct7b5_o  out  1  ins[30].
- opclass_o  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 MISC_MEM, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL.
- illegal_o  out  1  opclass_o==15.
- overflow_o  out  1  sticky: an offered instruction was dropped.

## Operation
- Push: stall_i=0 and flush_i=0. The pair {pc_i, ins_i} is written to the FIFO tail.
- Pop: the FIFO is non-empty and the output register is free, meaning valid_o=0 or ready_i=1. The head is decoded combinationally and loaded into the output register, and valid_o is set.
- Output register state machine:
  - EMPTY (valid_o=0) goes to FULL on a pop.
  - FULL goes to EMPTY when ready_i=1 and no pop happens.
  - FULL stays FULL and reloads when ready_i=1 and a pop happens.
  - FULL holds every output stable while ready_i=0.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Push and pop in the same cycle are both performed, whether the FIFO is full or empty. When the FIFO is full, the pop frees the slot that the push uses.
- Push while full with no pop in the same cycle: the instruction is dropped, overflow_o is set to 1 and holds until rst, and the FIFO contents are unchanged.
- Flush has priority over push and pop. In the cycle after flush_i=1:
  - the FIFO is empty;
  - valid_o=0;
  - the input offered in the flush cycle is discarded;
  - overflow_o is not affected.
- Illegal decode covers:
  - an unknown opcode;
  - ins[1:0]≠2'b11;
  - OP with funct7 not 0000000 or 0100000, unless the MULDIV case below applies;
  - invalid funct3 for LOAD, STORE, or BRANCH.
- Illegal instructions still flow down the pipeline with opclass 15 and imm_o=0.

## Timing
- Reset: all of the following are 0, and the FIFO is empty:
  - valid_o, pc_o, ins_o, rd_o, rs1_o, rs2_o, imm_o, funct3_o, funct7b5_o, overflow_o;
  - opclass_o=15, illegal_o=0;
  - ready_o=1.
- Latency: an instruction offered in cycle N (stall_i=0), with the FIFO empty and the output free, appears with valid_o=1 in cycle N+2.
- Throughput: one bundle per cycle while ready_i=1. Fetch currently offers at most one instruction every two cycles.
- All outputs are registered, with no combinational path from inputs to outputs. The exception is that ready_o is derived from registered pointers.
- Reset mid-operation: the next cycle shows reset values, regardless of flush_i or ready_i.

## Configuration
- DECODE_RV32M_EN defined: OP with funct7=0000001 decodes to opclass 11 (MULDIV), with rd/rs1/rs2 valid and imm 0.
- DECODE_RV32M_EN not defined: the same encoding decodes to opclass 15 (ILLEGAL).

## Test plan
- Reset, then offer ins=0x00500093 (addi x1,x0,5), pc=0x0 in cycle 3 with ready_i=1. Expect valid_o=1 in cycle 5, opclass 7, rd=1, rs1=0, imm=0x5, pc_o=0x0, for one cycle.
- Offer sw x2,-4(x1) = 0xFE20AE23. Expect opclass 6, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC. Offer beq x0,x0,-8 = 0xFE000CE3. Expect opclass 4, imm=0xFFFFFFF8.
- Hold ready_i=0 and offer DEPTH+2 instructions. Expect:
  - the output holds the first;
  - the FIFO holds the next DEPTH;
  - the last is dropped and overflow_o=1.
  - After releasing ready_i, the PCs come out in order with no gap.
- Fill the FIFO to 2 entries with valid_o=1 and assert flush_i with a new offer in the same cycle. Expect valid_o=0 and ready_o=1 in the next cycle, and the flush-cycle instruction never appears.
- Offer 0x02208033 (mul x0,x1,x2). With the macro defined, expect opclass 11. Without it, expect opclass 15 and illegal_o=1. Offer 0xFFFFFFFF and expect illegal_o=1 in both builds.
- Assert rst while valid_o=1 and the FIFO is non-empty. Expect all outputs at reset values in the next cycle.
